bcd_time_of_day: RTL and testbench

//  Parametrised successor wall-clock core: prescales the board clock to a 1 Hz tick and keeps HH:MM:SS in BCD.

---
 rtl/bcd_time_of_day_pkg.sv | 30 +++
 rtl/bcd_time_of_day_counter.sv | 54 +++++
 rtl/bcd_time_of_day.sv | 132 +++++++++++++
 tb/tb_bcd_time_of_day.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_time_of_day_pkg.sv
// Shared definitions for the BCD wall clock: digit width, field limits
// and the binary/BCD conversion helpers used by the counters and the 12h view.
package bcd_time_of_day_pkg;

    localparam int DIGIT_W    = 4;
    localparam int BIN_W      = 7;
    localparam int SEC_MAX    = 59;
    localparam int MIN_MAX    = 59;
    localparam int HOUR_MAX   = 23;
    localparam int H12_OFFSET = 12;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_pair_t;

    function automatic bcd_pair_t bin_to_bcd(input logic [BIN_W-1:0] value);
        bcd_pair_t pair;
        pair.tens = 4'(value / 7'd10);
        pair.ones = 4'(value % 7'd10);
        return pair;
    endfunction

    function automatic logic [BIN_W-1:0] bcd_to_bin(input bcd_pair_t pair);
        return ({3'd0, pair.tens} * 7'd10) + {3'd0, pair.ones};
    endfunction

endpackage

// File: rtl/bcd_time_of_day_counter.sv
// Two-digit BCD modulo counter (0..MAX) that can advance by 0, 1 or 2 per cycle;
// wrap reports that a carry-in arrived while the field sat at MAX.
module bcd_mod_counter
    import bcd_time_of_day_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [1:0] inc_amt,
    input  logic       carry_en,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap
);

    localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX);
    localparam logic [BIN_W-1:0] MOD_V = BIN_W'(MAX + 1);

    bcd_pair_t        value_r;
    logic [BIN_W-1:0] cur_s;
    logic [BIN_W-1:0] sum_s;
    logic [BIN_W-1:0] nxt_s;

    // Binary add with a single modulo correction (inc_amt never exceeds 2)
    always_comb begin
        cur_s = bcd_to_bin(value_r);
        sum_s = cur_s + {5'd0, inc_amt};
        if (sum_s > MAX_V) begin
            nxt_s = sum_s - MOD_V;
        end else begin
            nxt_s = sum_s;
        end
    end

    // Field state register; clear beats any increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= '0;
        end else if (clr) begin
            value_r <= '0;
        end else if (inc_amt != 2'd0) begin
            value_r <= bin_to_bcd(nxt_s);
        end else begin
            value_r <= value_r;
        end
    end

    assign wrap = carry_en & (cur_s == MAX_V);
    assign tens = value_r.tens;
    assign ones = value_r.ones;

endmodule

// File: rtl/bcd_time_of_day.sv
// Wall-clock core: prescaler to a one-second tick, HH:MM:SS in BCD with
// same-edge carry ripple, set pulses, seconds clear and a 12h/24h hour view.
module bcd_time_of_day
    import bcd_time_of_day_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int DIV_W    = 27
) (
    input  logic       CLK100MHZ,
    input  logic       RESET,
    input  logic       run,
    input  logic       clear_sec,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       mode_12h,
    output logic       sec_tick,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic       pm
);

    localparam logic [DIV_W-1:0] LAST_V = DIV_W'(TICK_DIV - 1);
    localparam logic [BIN_W-1:0] OFFS_V = BIN_W'(H12_OFFSET);

    logic [DIV_W-1:0] presc_r;
    logic             sec_tick_r;
    logic             tick_s;
    logic             min_carry_s;
    logic             hour_carry_s;
    logic [1:0]       sec_amt_s;
    logic [1:0]       min_amt_s;
    logic [1:0]       hour_amt_s;
    logic [3:0]       hour24_tens_s;
    logic [3:0]       hour24_ones_s;
    logic [BIN_W-1:0] hour_bin_s;
    logic [BIN_W-1:0] disp_bin_s;
    bcd_pair_t        disp_bcd_s;

    assign tick_s = run & (presc_r == LAST_V);

    // Prescaler; clear_sec restarts the second so the next tick is a full period away
    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            presc_r <= '0;
        end else if (clear_sec) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else if (run) begin
            presc_r <= presc_r + 1'b1;
        end else begin
            presc_r <= presc_r;
        end
    end

    // Tick pulse lands on the same edge as the time update
    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            sec_tick_r <= 1'b0;
        end else begin
            sec_tick_r <= tick_s;
        end
    end

    assign sec_tick = sec_tick_r;

    // Set pulses add to the carry but never produce one themselves
    assign sec_amt_s  = {1'b0, tick_s & ~clear_sec};
    assign min_amt_s  = {1'b0, min_carry_s} + {1'b0, inc_min};
    assign hour_amt_s = {1'b0, hour_carry_s} + {1'b0, inc_hour};

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk      (CLK100MHZ),
        .rst      (RESET),
        .clr      (clear_sec),
        .inc_amt  (sec_amt_s),
        .carry_en (sec_amt_s[0]),
        .tens     (sec_tens),
        .ones     (sec_ones),
        .wrap     (min_carry_s)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk      (CLK100MHZ),
        .rst      (RESET),
        .clr      (1'b0),
        .inc_amt  (min_amt_s),
        .carry_en (min_carry_s),
        .tens     (min_tens),
        .ones     (min_ones),
        .wrap     (hour_carry_s)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk      (CLK100MHZ),
        .rst      (RESET),
        .clr      (1'b0),
        .inc_amt  (hour_amt_s),
        .carry_en (1'b0),
        .tens     (hour24_tens_s),
        .ones     (hour24_ones_s),
        .wrap     ()
    );

    assign hour_bin_s = bcd_to_bin({hour24_tens_s, hour24_ones_s});
    assign pm         = (hour_bin_s >= OFFS_V);

    // 12h view: midnight hour shows as 12, afternoon hours fold down by 12
    always_comb begin
        disp_bin_s = hour_bin_s;
        if (mode_12h) begin
            if (hour_bin_s == 7'd0) begin
                disp_bin_s = OFFS_V;
            end else if (hour_bin_s > OFFS_V) begin
                disp_bin_s = hour_bin_s - OFFS_V;
            end else begin
                disp_bin_s = hour_bin_s;
            end
        end else begin
            disp_bin_s = hour_bin_s;
        end
        disp_bcd_s = bin_to_bcd(disp_bin_s);
    end

    assign hour_tens = disp_bcd_s.tens;
    assign hour_ones = disp_bcd_s.ones;

endmodule

// File: tb/tb_bcd_time_of_day.sv
// Randomised + directed bench for bcd_time_of_day with an arithmetic
// time-of-day model compared against every output on every falling edge.
module tb_bcd_time_of_day;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       clear_sec = 1'b0;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;
    logic       mode_12h = 1'b0;
    logic       sec_tick;
    logic [3:0] sec_tens, sec_ones, min_tens, min_ones, hour_tens, hour_ones;
    logic       pm;

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct packed {
        int   h;
        int   m;
        int   s;
        int   p;
        logic st;
    } mstate_t;

    mstate_t mdl;

    bcd_time_of_day #(.TICK_DIV(TD), .DIV_W(3)) dut (
        .CLK100MHZ (clk),
        .RESET     (rst),
        .run       (run),
        .clear_sec (clear_sec),
        .inc_min   (inc_min),
        .inc_hour  (inc_hour),
        .mode_12h  (mode_12h),
        .sec_tick  (sec_tick),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .hour_tens (hour_tens),
        .hour_ones (hour_ones),
        .pm        (pm)
    );

    always #5 clk = ~clk;

    function automatic mstate_t next_state(input mstate_t c, input logic r, input logic clr,
                                           input logic im, input logic ih);
        mstate_t n;
        bit tick, mc, hc;
        tick = r && (c.p == TD - 1);
        mc   = tick && !clr && (c.s == 59);
        hc   = mc && (c.m == 59);
        n.s  = clr ? 0 : (tick ? (c.s + 1) % 60 : c.s);
        n.m  = (c.m + int'(mc) + int'(im)) % 60;
        n.h  = (c.h + int'(hc) + int'(ih)) % 24;
        n.p  = clr ? 0 : (r ? (tick ? 0 : c.p + 1) : c.p);
        n.st = tick;
        return n;
    endfunction

    function automatic int disp_hour(input int h, input logic m12);
        if (!m12) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) mdl <= '0;
        else     mdl <= next_state(mdl, run, clear_sec, inc_min, inc_hour);
    end

    always @(negedge clk) begin
        int dh;
        dh = disp_hour(mdl.h, mode_12h);
        check("mdl_sec_tick",  int'(sec_tick),  int'(mdl.st));
        check("mdl_sec_tens",  int'(sec_tens),  mdl.s / 10);
        check("mdl_sec_ones",  int'(sec_ones),  mdl.s % 10);
        check("mdl_min_tens",  int'(min_tens),  mdl.m / 10);
        check("mdl_min_ones",  int'(min_ones),  mdl.m % 10);
        check("mdl_hour_tens", int'(hour_tens), dh / 10);
        check("mdl_hour_ones", int'(hour_ones), dh % 10);
        check("mdl_pm",        int'(pm),        int'(mdl.h >= 12));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check({name, "_h"}, int'(hour_tens) * 10 + int'(hour_ones), h);
        check({name, "_m"}, int'(min_tens) * 10 + int'(min_ones), m);
        check({name, "_s"}, int'(sec_tens) * 10 + int'(sec_ones), s);
    endtask

    task automatic do_reset();
        step();
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_min();
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
    endtask

    task automatic pulse_hour();
        inc_hour = 1'b1;
        step();
        inc_hour = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        run = 1'b0;
        do_reset();
        repeat (h) pulse_hour();
        repeat (m) pulse_min();
        run = 1'b1;
        repeat (s * TD) step();
        run = 1'b0;
        step();
    endtask

    initial begin
        int ticks;
        #1;
        check("reset_sec_tick", int'(sec_tick), 0);
        check_time("reset", 0, 0, 0);
        step();
        rst = 1'b0;

        // mid-count async reset, then one full period to the first tick
        set_time(10, 23, 45);
        check_time("set1", 10, 23, 45);
        run = 1'b1;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check_time("async_rst", 0, 0, 0);
        check("async_rst_tick", int'(sec_tick), 0);
        step();
        rst = 1'b0;
        repeat (TD) step();
        check("first_tick", int'(sec_tick), 1);
        check_time("first_tick", 0, 0, 1);
        run = 1'b0;

        // midnight rollover
        set_time(23, 59, 59);
        check("pm_before", int'(pm), 1);
        run = 1'b1;
        repeat (TD) step();
        check("midnight_tick", int'(sec_tick), 1);
        check_time("midnight", 0, 0, 0);
        check("pm_after", int'(pm), 0);
        run = 1'b0;

        // 12h display
        do_reset();
        mode_12h = 1'b1;
        #1;
        check("h12_00", int'(hour_tens) * 10 + int'(hour_ones), 12);
        check("h12_00_pm", int'(pm), 0);
        repeat (12) pulse_hour();
        check("h12_12", int'(hour_tens) * 10 + int'(hour_ones), 12);
        check("h12_12_pm", int'(pm), 1);
        pulse_hour();
        check("h12_13", int'(hour_tens) * 10 + int'(hour_ones), 1);
        repeat (10) pulse_hour();
        check("h12_23", int'(hour_tens) * 10 + int'(hour_ones), 11);
        check("h12_23_pm", int'(pm), 1);
        mode_12h = 1'b0;
        #1;
        check("h24_23", int'(hour_tens) * 10 + int'(hour_ones), 23);

        // set pulses do not carry
        set_time(10, 59, 30);
        pulse_min();
        check_time("inc_min_wrap", 10, 0, 30);
        set_time(23, 15, 0);
        pulse_hour();
        check_time("inc_hour_wrap", 0, 15, 0);

        // tick and inc_min on the same edge
        set_time(10, 58, 59);
        run = 1'b1;
        repeat (TD - 1) step();
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
        run = 1'b0;
        check_time("tick_inc_a", 10, 0, 0);
        set_time(10, 59, 59);
        run = 1'b1;
        repeat (TD - 1) step();
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
        run = 1'b0;
        check_time("tick_inc_b", 11, 1, 0);

        // clear_sec coinciding with a tick, then pause
        set_time(5, 7, 59);
        run = 1'b1;
        repeat (TD - 1) step();
        clear_sec = 1'b1;
        step();
        clear_sec = 1'b0;
        check_time("clear_tick", 5, 7, 0);
        check("clear_tick_pulse", int'(sec_tick), 1);
        repeat (TD) step();
        check_time("after_clear", 5, 7, 1);
        check("after_clear_tick", int'(sec_tick), 1);
        run = 1'b0;
        ticks = 0;
        repeat (20) begin
            step();
            ticks += int'(sec_tick);
        end
        check("pause_ticks", ticks, 0);
        check_time("pause_hold", 5, 7, 1);

        // randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            run       = ($urandom_range(0, 9) != 0);
            inc_min   = ($urandom_range(0, 15) == 0);
            inc_hour  = ($urandom_range(0, 15) == 0);
            clear_sec = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) mode_12h = ~mode_12h;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
